alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_req_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU among NUM_REQ requesters.
// Define ALU_ARB_TIMEOUT_EN to compile in the RUN-state watchdog.
module alu_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int RESULT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*3-1:0]          req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [RESULT_WIDTH-1:0]       rsp_result,
  output logic                          alu_start_op,
  output logic [2:0]                    alu_op_sel,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  input  logic [RESULT_WIDTH-1:0]       alu_result,
  input  logic                          alu_end_op,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [OWNER_W-1:0]      owner_reg;
  logic [OWNER_W-1:0]      last_owner_reg;
  logic [2:0]              op_reg;
  logic [DATA_WIDTH-1:0]   a_reg;
  logic [DATA_WIDTH-1:0]   b_reg;
  logic [RESULT_WIDTH-1:0] result_reg;

  logic [OWNER_W-1:0]      grant_idx_next;
  logic [OWNER_W-1:0]      cand_idx;
  logic                    grant_found_next;
  logic                    grant_en;

  logic [2:0]              op_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]   a_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   b_arr  [NUM_REQ];

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_reg;
`endif

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op_arr[gi]    = req_op[3*gi +: 3];
      assign a_arr[gi]     = req_a[DATA_WIDTH*gi +: DATA_WIDTH];
      assign b_arr[gi]     = req_b[DATA_WIDTH*gi +: DATA_WIDTH];
      assign req_ready[gi] = grant_en && (grant_idx_next == OWNER_W'(gi));
      assign rsp_valid[gi] = (state_reg == ST_DONE) && (owner_reg == OWNER_W'(gi));
    end
  endgenerate

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    grant_found_next = 1'b0;
    grant_idx_next   = '0;
    cand_idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = OWNER_W'((int'(last_owner_reg) + k) % NUM_REQ);
      if (!grant_found_next && req_valid[cand_idx]) begin
        grant_found_next = 1'b1;
        grant_idx_next   = cand_idx;
      end
    end
  end

  // A lingering end_op in IDLE belongs to the previous operation, so it holds off the grant.
  assign grant_en = rst_n && (state_reg == ST_IDLE) && grant_found_next && !alu_end_op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= '0;
      last_owner_reg <= OWNER_W'(NUM_REQ - 1);
      op_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      result_reg     <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      wd_cnt_reg     <= '0;
      timeout_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_en) begin
            owner_reg <= grant_idx_next;
            op_reg    <= op_arr[grant_idx_next];
            a_reg     <= a_arr[grant_idx_next];
            b_reg     <= b_arr[grant_idx_next];
            state_reg <= ST_RUN;
`ifdef ALU_ARB_TIMEOUT_EN
            wd_cnt_reg <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (alu_end_op) begin
            result_reg <= alu_result;
            state_reg  <= ST_DONE;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          // Give up on a hung ALU but still complete so the requester is released.
          else if (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
            result_reg  <= '1;
            timeout_reg <= 1'b1;
            state_reg   <= ST_DONE;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          last_owner_reg <= owner_reg;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign alu_start_op = (state_reg == ST_RUN);
  assign alu_op_sel   = alu_start_op ? op_reg : 3'b000;
  assign alu_a        = alu_start_op ? a_reg : '0;
  assign alu_b        = alu_start_op ? b_reg : '0;
  assign rsp_result   = result_reg;

`ifdef ALU_ARB_TIMEOUT_EN
  assign timeout_err = timeout_reg;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: per-cycle comparison against a transaction-level
// model plus literal checks of grant order, results and latency.
module tb_alu_req_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*3-1:0]  req_op = '0;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [RW-1:0]   rsp_result, alu_result;
  logic            alu_start_op, alu_end_op, busy, timeout_err;
  logic [2:0]      alu_op_sel;
  logic [DW-1:0]   alu_a, alu_b;

  alu_req_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .alu_start_op(alu_start_op), .alu_op_sel(alu_op_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_end_op(alu_end_op),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000:  return {16'h0, a} * {16'h0, b};
      3'b001:  return {16'h0, a} + {16'h0, b};
      default: return {16'h0, a} - {16'h0, b};
    endcase
  endfunction

  // ALU stub: end_op rises in the last cycle of the op (MUL 3 cycles, others 1).
  logic [2:0] lat_cnt = 3'd0;
  logic       force_end = 1'b0;
  logic       hang = 1'b0;
  always @(posedge clk) lat_cnt <= alu_start_op ? lat_cnt + 3'd1 : 3'd0;
  assign alu_end_op = force_end |
                      (!hang && alu_start_op && (lat_cnt == ((alu_op_sel == 3'b000) ? 3'd2 : 3'd0)));
  assign alu_result = alu_fn(alu_op_sel, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  // Transaction-level model
  bit             m_pending = 0, m_end = 0, m_to = 0;
  int             m_owner = 0, m_last = N - 1, m_run = 0;
  logic [2:0]     m_op = '0;
  logic [DW-1:0]  m_a = '0, m_b = '0;
  logic [RW-1:0]  m_result = '0;
  logic [N-1:0]   exp_ready, exp_rsp, ready_seen = '0;
  logic           exp_start;
  int             cyc = 0, t_acc = 0, start_cnt = 0, pick;
  int             grant_q[$];
  int             lat_q[$];
  logic [RW-1:0]  rsp_q[$];

  always @(negedge clk) begin
    cyc++;
    exp_ready = '0;
    pick = rr_pick(req_valid, m_last);
    if (!m_pending && rst_n && !alu_end_op && (req_valid != '0)) exp_ready = N'(1) << pick;
    exp_start = m_pending && !m_end;
    exp_rsp   = (m_pending && m_end) ? (N'(1) << m_owner) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    chk("alu_start_op", 32'(alu_start_op), 32'(exp_start));
    chk("busy", 32'(busy), 32'(m_pending));
    chk("rsp_result", rsp_result, m_result);
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
    if (exp_start) begin
      chk("alu_cmd_run", {alu_op_sel, alu_a[12:0], alu_b}, {m_op, m_a[12:0], m_b});
      chk("alu_a_run", 32'(alu_a), 32'(m_a));
    end else if (!m_pending) begin
      chk("alu_cmd_idle", {13'h0, alu_op_sel, alu_a}, 32'(alu_b));
    end
    // event log for the directed literal checks
    ready_seen = req_ready;
    for (int i = 0; i < N; i++) if (req_ready[i]) begin grant_q.push_back(i); t_acc = cyc; end
    if (rsp_valid != '0) begin rsp_q.push_back(rsp_result); lat_q.push_back(cyc - t_acc + 1); end
    if (alu_start_op) start_cnt++;
    // advance the model across the coming edge
    if (!rst_n) begin
      m_pending = 0; m_end = 0; m_last = N - 1; m_result = '0; m_to = 0;
    end else if (exp_ready != '0) begin
      m_pending = 1; m_end = 0; m_run = 0; m_owner = pick;
      m_op = req_op[3*pick +: 3]; m_a = req_a[DW*pick +: DW]; m_b = req_b[DW*pick +: DW];
    end else if (m_pending && !m_end) begin
      if (alu_end_op) begin
        m_end = 1; m_result = alu_fn(m_op, m_a, m_b);
      end else begin
        m_run++;
`ifdef ALU_ARB_TIMEOUT_EN
        if (m_run == 10) begin m_end = 1; m_result = '1; m_to = 1; end
`endif
      end
    end else if (m_pending && m_end) begin
      m_pending = 0; m_last = m_owner;
    end
  end

  // hold_mask requesters keep req_valid up after being granted; the others drop it.
  logic [N-1:0] hold_mask = '0;
  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(ready_seen & ~hold_mask);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op[3*i +: 3] = op;
    req_a[DW*i +: DW] = a;
    req_b[DW*i +: DW] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; hold_mask = '0; hang = 1'b0; force_end = 1'b0;
    run(2);
    rst_n = 1'b1;
    grant_q.delete(); rsp_q.delete(); lat_q.delete(); start_cnt = 0;
  endtask

  task automatic chk_int(input string name, input int q[$], input int idx, input int exp);
    if (idx < q.size()) chk(name, 32'(q[idx]), 32'(exp));
    else begin vectors++; errors++; $display("FAIL %s: entry %0d missing, expected %0d", name, idx, exp); end
  endtask

  task automatic chk_res(input string name, input int idx, input logic [31:0] exp);
    if (idx < rsp_q.size()) chk(name, rsp_q[idx], exp);
    else begin vectors++; errors++; $display("FAIL %s: response %0d missing, expected 0x%0h", name, idx, exp); end
  endtask

  initial begin
    do_reset();
    chk("reset_outputs", {req_ready, rsp_valid, 3'b0, alu_start_op, busy, timeout_err, alu_op_sel, alu_a[14:0]}, 32'h0);
    chk("reset_result", rsp_result, 32'h0);

    // Single ADD on a 1-cycle ALU
    set_req(0, 3'b001, 16'd42, 16'd21);
    req_valid = 4'b0001;
    run(6);
    chk("t1_ngrants", 32'(grant_q.size()), 32'd1);
    chk_int("t1_grant", grant_q, 0, 0);
    chk("t1_nrsp", 32'(rsp_q.size()), 32'd1);
    chk_res("t1_result", 0, 32'd63);
    chk_int("t1_latency", lat_q, 0, 3);
    chk("t1_start_cycles", 32'(start_cnt), 32'd1);

    // Four simultaneous MULs, then 2 and 0 held continuously
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 3'b000, 16'd2, 16'(3 + i));
    req_valid = 4'b1111;
    run(25);
    for (int i = 0; i < N; i++) begin
      chk_int($sformatf("t2_grant%0d", i), grant_q, i, i);
      chk_res($sformatf("t2_result%0d", i), i, 32'(6 + 2 * i));
    end
    grant_q.delete();
    hold_mask = 4'b0101;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0101;
    run(22);
    chk_int("t2_alt0", grant_q, 0, 2);
    chk_int("t2_alt1", grant_q, 1, 0);
    chk_int("t2_alt2", grant_q, 2, 2);
    chk_int("t2_alt3", grant_q, 3, 0);
    hold_mask = '0; req_valid = '0;
    run(8);

    // 3-cycle MUL of the largest operands
    do_reset();
    set_req(1, 3'b000, 16'hFFFF, 16'hFFFF);
    req_valid = 4'b0010;
    run(8);
    chk_int("t3_grant", grant_q, 0, 1);
    chk_res("t3_result", 0, 32'hFFFE0001);
    chk_int("t3_latency", lat_q, 0, 5);

    // Stale end_op in IDLE blocks grants until it falls
    do_reset();
    set_req(3, 3'b001, 16'd1, 16'd1);
    force_end = 1'b1;
    req_valid = 4'b1000;
    run(4);
    chk("t4_blocked", 32'(grant_q.size()), 32'd0);
    force_end = 1'b0;
    run(5);
    chk_int("t4_grant", grant_q, 0, 3);
    chk_res("t4_result", 0, 32'd2);

    // Reset in the middle of a MUL
    do_reset();
    set_req(0, 3'b000, 16'd7, 16'd9);
    req_valid = 4'b0001;
    run(2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_outputs", {req_ready, rsp_valid, 3'b0, alu_start_op, busy, timeout_err, alu_op_sel, alu_a[14:0]}, 32'h0);
    chk("t5_alu_b", 32'(alu_b), 32'h0);
    chk("t5_result", rsp_result, 32'h0);
    run(4);
    chk("t5_no_rsp", 32'(rsp_q.size()), 32'd0);
    grant_q.delete();
    set_req(0, 3'b001, 16'd5, 16'd6);
    set_req(3, 3'b001, 16'd8, 16'd9);
    req_valid = 4'b1001;
    run(10);
    chk_int("t5_first", grant_q, 0, 0);
    chk_int("t5_second", grant_q, 1, 3);

    // ALU that never finishes
    do_reset();
    hang = 1'b1;
    set_req(0, 3'b001, 16'd1, 16'd2);
    req_valid = 4'b0001;
    run(20);
`ifdef ALU_ARB_TIMEOUT_EN
    chk_res("t6_result", 0, 32'hFFFFFFFF);
    chk_int("t6_latency", lat_q, 0, 12);
    chk("t6_start_cycles", 32'(start_cnt), 32'd10);
    chk("t6_timeout_err", 32'(timeout_err), 32'd1);
    chk("t6_idle", 32'(busy), 32'd0);
`else
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_no_rsp", 32'(rsp_q.size()), 32'd0);
    chk("t6_timeout_err", 32'(timeout_err), 32'd0);
`endif
    do_reset();
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
